// File: rtl/clock_ctrl_pkg.sv
// Shared types, BCD constants and the BCD increment helper for the
// front-panel clock-set sequencer.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_HH = 3'd1,
    SET_MM = 3'd2,
    SET_SS = 3'd3,
    COMMIT = 3'd4
  } state_e;

  localparam logic [7:0] HH_MIN     = 8'h01;
  localparam logic [7:0] HH_MAX     = 8'h12;
  localparam logic [7:0] MS_MIN     = 8'h00;
  localparam logic [7:0] MS_MAX     = 8'h59;
  localparam logic [7:0] HH_PM_EDGE = 8'h11;

  // Two-digit BCD +1 that wraps from max back to min. A value at or past
  // max also wraps, so a corrupt shadow recovers to a legal BCD value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value,
                                         input logic [7:0] max,
                                         input logic [7:0] min);
    logic [7:0] result;
    if (value >= max) begin
      result = min;
    end else if (value[3:0] >= 4'd9) begin
      result = {value[7:4] + 4'd1, 4'h0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/ctrl_tick_gen.sv
// Free-running prescaler with run/clear control. tick is high for the single
// cycle in which the count sits at DIV-1 while running; the count then wraps.
module ctrl_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] count;

  assign tick = run && (count == LAST);

  // Prescaler: clear has priority, holds when not running, wraps after LAST.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of its neighbours, independent of block order.
    if (reset || clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Front-panel sequencer for the 12-hour BCD time-of-day counter chain:
// produces the 1 Hz count enable while running and a button-driven set mode
// that edits shadow hh/mm/ss/pm registers and commits them with a load strobe.
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  input  logic       cur_pm,
  output logic       clk_ena,
  output logic       load,
  output logic [7:0] ld_hh,
  output logic [7:0] ld_mm,
  output logic [7:0] ld_ss,
  output logic       ld_pm,
  output logic [2:0] field_sel,
  output logic       blink
);

  state_e state, next_state;
  logic   in_set;
  logic   sec_run, sec_clear;
  logic   blink_run, blink_clear, blink_tick;
  logic   do_inc;

  // Time only advances in RUN; COMMIT restarts the second from zero so the
  // first enable after a commit is a full TICK_DIV cycles later.
  assign sec_run   = (state == RUN);
  assign sec_clear = (state == COMMIT);

  // Blink timebase restarts on every field change and is idle outside set mode.
  assign blink_clear = !in_set || (next_state != state);
  assign blink_run   = !blink_clear;

  // Mode has priority: an increment arriving with a mode press is dropped.
  assign do_inc = btn_inc && !btn_mode;

  ctrl_tick_gen #(.DIV(TICK_DIV)) u_sec_tick (
    .clk   (clk),
    .reset (reset),
    .run   (sec_run),
    .clear (sec_clear),
    .tick  (clk_ena)
  );

  ctrl_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk   (clk),
    .reset (reset),
    .run   (blink_run),
    .clear (blink_clear),
    .tick  (blink_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    next_state = state;
    load       = 1'b0;
    field_sel  = 3'b000;
    in_set     = 1'b0;
    case (state)
      RUN: begin
        if (btn_mode) next_state = SET_HH;
      end
      SET_HH: begin
        field_sel = 3'b100;
        in_set    = 1'b1;
        if (btn_mode) next_state = SET_MM;
      end
      SET_MM: begin
        field_sel = 3'b010;
        in_set    = 1'b1;
        if (btn_mode) next_state = SET_SS;
      end
      SET_SS: begin
        field_sel = 3'b001;
        in_set    = 1'b1;
        if (btn_mode) next_state = COMMIT;
      end
      COMMIT: begin
        load       = 1'b1;
        next_state = RUN;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // Shadow time registers: captured from the live chain on entry to set mode,
  // edited field by field, held unchanged everywhere else.
  always_ff @(posedge clk) begin
    // NOTE: the shadows drive output ports the chain can load, so they are
    // reset to a known legal time rather than left undefined.
    if (reset) begin
      ld_hh <= HH_MAX;
      ld_mm <= MS_MIN;
      ld_ss <= MS_MIN;
      ld_pm <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (btn_mode) begin
            ld_hh <= cur_hh;
            ld_mm <= cur_mm;
            ld_ss <= cur_ss;
            ld_pm <= cur_pm;
          end
        end
        SET_HH: begin
          if (do_inc) begin
            ld_hh <= bcd_inc(ld_hh, HH_MAX, HH_MIN);
            // 11 -> 12 flips AM/PM, mirroring the counter chain's rollover.
            if (ld_hh == HH_PM_EDGE) ld_pm <= ~ld_pm;
          end
        end
        SET_MM: begin
          if (do_inc) ld_mm <= bcd_inc(ld_mm, MS_MAX, MS_MIN);
        end
        SET_SS: begin
          // Seconds are zeroed rather than stepped, for syncing to a reference.
          if (do_inc) ld_ss <= MS_MIN;
        end
        default: begin
        end
      endcase
    end
  end

  // Display blink phase: toggles on each blink tick while editing.
  always_ff @(posedge clk) begin
    if (reset || blink_clear) begin
      blink <= 1'b0;
    end else if (blink_tick) begin
      blink <= ~blink;
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller with TICK_DIV=4, BLINK_DIV=2.
// Expected outputs are queued as each cycle's buttons are driven and popped
// and compared on the following falling edge.
module tb_clock_set_controller;

  localparam int TICK_DIV  = 4;
  localparam int BLINK_DIV = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] cur_hh = 8'h00;
  logic [7:0] cur_mm = 8'h00;
  logic [7:0] cur_ss = 8'h00;
  logic       cur_pm = 1'b0;
  logic       clk_ena, load, ld_pm, blink;
  logic [7:0] ld_hh, ld_mm, ld_ss;
  logic [2:0] field_sel;

  always #5 clk = ~clk;

  clock_set_controller #(
    .TICK_DIV  (TICK_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .cur_hh    (cur_hh),
    .cur_mm    (cur_mm),
    .cur_ss    (cur_ss),
    .cur_pm    (cur_pm),
    .clk_ena   (clk_ena),
    .load      (load),
    .ld_hh     (ld_hh),
    .ld_mm     (ld_mm),
    .ld_ss     (ld_ss),
    .ld_pm     (ld_pm),
    .field_sel (field_sel),
    .blink     (blink)
  );

  typedef enum int {S_CLK_ENA, S_LOAD, S_HH, S_MM, S_SS, S_PM, S_FSEL, S_BLINK} sig_e;
  typedef struct {
    string      tag;
    sig_e       sig;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] observe(input sig_e s);
    logic [7:0] r;
    case (s)
      S_CLK_ENA: r = {7'd0, clk_ena};
      S_LOAD:    r = {7'd0, load};
      S_HH:      r = ld_hh;
      S_MM:      r = ld_mm;
      S_SS:      r = ld_ss;
      S_PM:      r = {7'd0, ld_pm};
      S_FSEL:    r = {5'd0, field_sel};
      default:   r = {7'd0, blink};
    endcase
    return r;
  endfunction

  // Decimal 0..99 to two-digit BCD, independent of the RUT's nibble logic.
  function automatic logic [7:0] to_bcd(input int d);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  task automatic expect_out(input string tag, input sig_e s, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_time(input string tag, input logic [7:0] hh, input logic [7:0] mm,
                             input logic [7:0] ss, input logic pm);
    expect_out({tag, "_hh"}, S_HH, hh);
    expect_out({tag, "_mm"}, S_MM, mm);
    expect_out({tag, "_ss"}, S_SS, ss);
    expect_out({tag, "_pm"}, S_PM, {7'd0, pm});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
  endtask

  // Drive one cycle of buttons from a falling edge, then compare on the next.
  task automatic cycle(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    @(posedge clk);
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state.
    expect_out("rst_clk_ena", S_CLK_ENA, 8'd0);
    expect_out("rst_load",    S_LOAD,    8'd0);
    expect_out("rst_fsel",    S_FSEL,    8'd0);
    expect_out("rst_blink",   S_BLINK,   8'd0);
    expect_time("rst", 8'h12, 8'h00, 8'h00, 1'b0);
    drain();
    reset = 1'b0;

    // Idle RUN: enable on RUN cycles 4, 8, 12.
    for (int n = 1; n <= 11; n++) begin
      expect_out($sformatf("idle_clk_ena_%0d", n + 1), S_CLK_ENA, {7'd0, ((n + 1) % 4 == 0)});
      expect_out($sformatf("idle_load_%0d", n + 1), S_LOAD, 8'd0);
      cycle(1'b0, 1'b0);
    end
    expect_time("idle", 8'h12, 8'h00, 8'h00, 1'b0);
    drain();

    // Enter SET_HH, capturing 11:30:45 AM.
    cur_hh = 8'h11; cur_mm = 8'h30; cur_ss = 8'h45; cur_pm = 1'b0;
    expect_out("sethh_fsel",    S_FSEL,    8'h04);
    expect_out("sethh_clk_ena", S_CLK_ENA, 8'd0);
    expect_out("sethh_blink",   S_BLINK,   8'd0);
    expect_time("capture", 8'h11, 8'h30, 8'h45, 1'b0);
    cycle(1'b1, 1'b0);

    // 11 -> 12 toggles PM.
    expect_out("hh_inc_hh",      S_HH,      8'h12);
    expect_out("hh_inc_pm",      S_PM,      8'd1);
    expect_out("hh_inc_fsel",    S_FSEL,    8'h04);
    expect_out("hh_inc_clk_ena", S_CLK_ENA, 8'd0);
    cycle(1'b0, 1'b1);

    // Blink toggles after BLINK_DIV cycles in the field.
    expect_out("blink_on",      S_BLINK,   8'd1);
    expect_out("blink_hh_hold", S_HH,      8'h12);
    expect_out("blink_clk_ena", S_CLK_ENA, 8'd0);
    cycle(1'b0, 1'b0);

    // SET_MM: blink restarts, then step minutes 30 -> 59.
    expect_out("setmm_fsel",  S_FSEL,  8'h02);
    expect_out("setmm_blink", S_BLINK, 8'd0);
    expect_out("setmm_mm",    S_MM,    8'h30);
    cycle(1'b1, 1'b0);
    for (int k = 31; k <= 59; k++) begin
      expect_out($sformatf("mm_step_%0d", k), S_MM, to_bcd(k));
      cycle(1'b0, 1'b1);
    end

    // 59 -> 00 -> 01 with no carry into hours.
    expect_out("mm_wrap",    S_MM, 8'h00);
    expect_out("mm_wrap_hh", S_HH, 8'h12);
    cycle(1'b0, 1'b1);
    expect_out("mm_01",    S_MM, 8'h01);
    expect_out("mm_01_hh", S_HH, 8'h12);
    expect_out("mm_01_pm", S_PM, 8'd1);
    cycle(1'b0, 1'b1);

    // Mode and inc together: mode wins.
    expect_out("both_fsel", S_FSEL, 8'h01);
    expect_out("both_mm",   S_MM,   8'h01);
    expect_out("both_ss",   S_SS,   8'h45);
    cycle(1'b1, 1'b1);

    // Seconds zeroed.
    expect_out("ss_zero",      S_SS,   8'h00);
    expect_out("ss_zero_fsel", S_FSEL, 8'h01);
    cycle(1'b0, 1'b1);

    // COMMIT: one load pulse with the edited time.
    expect_out("commit_load",    S_LOAD,    8'd1);
    expect_out("commit_clk_ena", S_CLK_ENA, 8'd0);
    expect_out("commit_fsel",    S_FSEL,    8'd0);
    expect_out("commit_blink",   S_BLINK,   8'd0);
    expect_time("commit", 8'h12, 8'h01, 8'h00, 1'b1);
    cycle(1'b1, 1'b0);

    // First enable exactly TICK_DIV cycles into RUN.
    for (int n = 1; n <= 4; n++) begin
      expect_out($sformatf("post_commit_clk_ena_%0d", n), S_CLK_ENA, {7'd0, (n == 4)});
      expect_out($sformatf("post_commit_load_%0d", n), S_LOAD, 8'd0);
      cycle(1'b0, 1'b0);
    end
    expect_time("hold", 8'h12, 8'h01, 8'h00, 1'b1);
    drain();

    // btn_inc ignored in RUN.
    expect_out("run_inc_fsel", S_FSEL, 8'd0);
    expect_time("run_inc", 8'h12, 8'h01, 8'h00, 1'b1);
    cycle(1'b0, 1'b1);

    // Second session: 12 -> 01 leaves PM alone.
    cur_hh = 8'h12; cur_mm = 8'h00; cur_ss = 8'h00; cur_pm = 1'b1;
    expect_out("s2_hh", S_HH, 8'h12);
    expect_out("s2_pm", S_PM, 8'd1);
    cycle(1'b1, 1'b0);
    expect_out("hh_wrap",    S_HH, 8'h01);
    expect_out("hh_wrap_pm", S_PM, 8'd1);
    cycle(1'b0, 1'b1);
    expect_out("s2_blink", S_BLINK, 8'd1);
    cycle(1'b0, 1'b0);

    // Reset mid-edit: shadows discarded, back in RUN, no load.
    reset = 1'b1;
    expect_out("mid_rst_fsel",  S_FSEL,  8'd0);
    expect_out("mid_rst_load",  S_LOAD,  8'd0);
    expect_out("mid_rst_blink", S_BLINK, 8'd0);
    expect_time("mid_rst", 8'h12, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 1'b0);
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      expect_out($sformatf("after_rst_load_%0d", n), S_LOAD, 8'd0);
      expect_out($sformatf("after_rst_clk_ena_%0d", n), S_CLK_ENA, {7'd0, (n == 3)});
      cycle(1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
